// File: rtl/riscv_formal_monitor_rv32imc_if.sv
// Purpose: RVFI retirement bus bundle, NRET channels packed side by side.
// Latency: none, plain wires.
// Backpressure: none; the retiring core drives it and the monitor always samples.
// Ports: master = retiring core (drives every field), slave = monitor (reads every field).
// Channel i of each packed field sits at [i*W +: W], where W is the per-channel width.
interface riscv_formal_monitor_rv32imc_if #(
   parameter int NRET = 8,
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   logic [NRET-1:0]          rvfi_valid;
   logic [NRET*64-1:0]       rvfi_order;
   logic [NRET*ILEN-1:0]     rvfi_insn;
   logic [NRET-1:0]          rvfi_trap;
   logic [NRET-1:0]          rvfi_halt;
   logic [NRET-1:0]          rvfi_intr;
   logic [NRET*2-1:0]        rvfi_mode;
   logic [NRET*5-1:0]        rvfi_rs1_addr;
   logic [NRET*5-1:0]        rvfi_rs2_addr;
   logic [NRET*5-1:0]        rvfi_rd_addr;
   logic [NRET*XLEN-1:0]     rvfi_rs1_rdata;
   logic [NRET*XLEN-1:0]     rvfi_rs2_rdata;
   logic [NRET*XLEN-1:0]     rvfi_rd_wdata;
   logic [NRET*XLEN-1:0]     rvfi_pc_rdata;
   logic [NRET*XLEN-1:0]     rvfi_pc_wdata;
   logic [NRET*XLEN-1:0]     rvfi_mem_addr;
   logic [NRET*XLEN-1:0]     rvfi_mem_rdata;
   logic [NRET*XLEN-1:0]     rvfi_mem_wdata;
   logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask;
   logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask;
   logic [NRET-1:0]          rvfi_mem_extamo;

   modport master (
      output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
             rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata,
             rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_extamo
   );

   modport slave (
      input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
             rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata,
             rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_extamo
   );
endinterface

// File: rtl/riscv_formal_monitor_rv32imc.sv
// Purpose: RVFI retirement monitor for RV32IMC. It checks order, PC chain, shadow register
//          reads, x0 writes, halt, trap, compressed encoding and memory masks.
// Latency: errcode registers the first error one clock after the offending retirement is sampled.
// Backpressure: none. The monitor samples every cycle. errcode is sticky until reset.
// Ports: clock, reset (async active-low), rvfi (slave bundle), errcode (0 = clean, else 101..110).
module riscv_formal_monitor_rv32imc #(
   parameter int NRET = 8,
   parameter int XLEN = 32,
   parameter int ILEN = 32
) (
   input  logic                           clock,
   input  logic                           reset,
   riscv_formal_monitor_rv32imc_if.slave  rvfi,
   output logic [15:0]                    errcode
);
   localparam int MW = XLEN / 8;

   // Architectural tracking state
   logic [63:0]      order_q;
   logic [XLEN-1:0]  prev_pc_q;
   logic             pc_vld_q;
   logic             halted_q;
   logic [31:0]      known_q;
   logic [XLEN-1:0]  regs_q [32];

   // State after all valid channels of this cycle have been applied in order
   logic [63:0]      order_c;
   logic [XLEN-1:0]  pc_c;
   logic             pc_vld_c;
   logic             halted_c;
   logic [31:0]      known_c;
   logic [XLEN-1:0]  regs_c [32];
   logic [15:0]      err_c;

   // Per-channel working values, reused on each loop iteration
   logic [15:0]      ch_code;
   logic [63:0]      c_order;
   logic [ILEN-1:0]  c_insn;
   logic [4:0]       c_rs1;
   logic [4:0]       c_rs2;
   logic [4:0]       c_rd;
   logic [XLEN-1:0]  c_rs1d;
   logic [XLEN-1:0]  c_rs2d;
   logic [XLEN-1:0]  c_rdd;
   logic [XLEN-1:0]  c_pcr;
   logic [XLEN-1:0]  c_pcw;
   logic [MW-1:0]    c_rm;
   logic [MW-1:0]    c_wm;
   logic             c_bad1;
   logic             c_bad2;

   // Byte, aligned halfword and full word are the only legal access shapes.
   function automatic logic mask_legal(input logic [MW-1:0] m);
      return (m == 4'b0000) || (m == 4'b0001) || (m == 4'b0010) || (m == 4'b0100) ||
             (m == 4'b1000) || (m == 4'b0011) || (m == 4'b1100) || (m == 4'b1111);
   endfunction

   // Walk the channels in ascending order as a chain of retirements. Each valid channel
   // sees the order, PC, halt and register state left by the lower channels. The first
   // nonzero channel code is the cycle's error. Within a channel, the if/else chain runs
   // in code order, so the lowest code number wins.
   always_comb begin
      order_c  = order_q;
      pc_c     = prev_pc_q;
      pc_vld_c = pc_vld_q;
      halted_c = halted_q;
      known_c  = known_q;
      regs_c   = regs_q;
      err_c    = '0;
      ch_code  = '0;
      c_order  = '0;
      c_insn   = '0;
      c_rs1    = '0;
      c_rs2    = '0;
      c_rd     = '0;
      c_rs1d   = '0;
      c_rs2d   = '0;
      c_rdd    = '0;
      c_pcr    = '0;
      c_pcw    = '0;
      c_rm     = '0;
      c_wm     = '0;
      c_bad1   = 1'b0;
      c_bad2   = 1'b0;
      for (int i = 0; i < NRET; i++) begin
         c_order = rvfi.rvfi_order[i*64 +: 64];
         c_insn  = rvfi.rvfi_insn[i*ILEN +: ILEN];
         c_rs1   = rvfi.rvfi_rs1_addr[i*5 +: 5];
         c_rs2   = rvfi.rvfi_rs2_addr[i*5 +: 5];
         c_rd    = rvfi.rvfi_rd_addr[i*5 +: 5];
         c_rs1d  = rvfi.rvfi_rs1_rdata[i*XLEN +: XLEN];
         c_rs2d  = rvfi.rvfi_rs2_rdata[i*XLEN +: XLEN];
         c_rdd   = rvfi.rvfi_rd_wdata[i*XLEN +: XLEN];
         c_pcr   = rvfi.rvfi_pc_rdata[i*XLEN +: XLEN];
         c_pcw   = rvfi.rvfi_pc_wdata[i*XLEN +: XLEN];
         c_rm    = rvfi.rvfi_mem_rmask[i*MW +: MW];
         c_wm    = rvfi.rvfi_mem_wmask[i*MW +: MW];
         // x0 must read as zero. An unknown shadow register cannot be checked yet.
         c_bad1  = (c_rs1 == 5'd0) ? (c_rs1d != '0) : (known_c[c_rs1] && (c_rs1d != regs_c[c_rs1]));
         c_bad2  = (c_rs2 == 5'd0) ? (c_rs2d != '0) : (known_c[c_rs2] && (c_rs2d != regs_c[c_rs2]));
         ch_code = '0;
         if (rvfi.rvfi_valid[i]) begin
            if (c_order != order_c)
               ch_code = 16'd101;
            else if (pc_vld_c && (c_pcr != pc_c))
               ch_code = 16'd102;
            else if (c_bad1)
               ch_code = 16'd103;
            else if (c_bad2)
               ch_code = 16'd104;
            else if ((c_rd == 5'd0) && (c_rdd != '0))
               ch_code = 16'd105;
            else if (halted_c)
               ch_code = 16'd106;
            else if (rvfi.rvfi_trap[i] || rvfi.rvfi_intr[i])
               ch_code = 16'd107;
            else if ((c_insn[1:0] != 2'b11) && (c_insn[ILEN-1:16] != '0))
               ch_code = 16'd108;
            else if ((c_rm != '0) && (c_wm != '0))
               ch_code = 16'd109;
            else if (!mask_legal(c_rm) || !mask_legal(c_wm))
               ch_code = 16'd110;

            if (err_c == '0)
               err_c = ch_code;

            // Tracking state follows the retirement even when it raised an error.
            order_c  = order_c + 64'd1;
            pc_c     = c_pcw;
            pc_vld_c = 1'b1;
            halted_c = halted_c | rvfi.rvfi_halt[i];
            if (c_rd != 5'd0) begin
               regs_c[c_rd]  = c_rdd;
               known_c[c_rd] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         errcode   <= '0;
         order_q   <= '0;
         prev_pc_q <= '0;
         pc_vld_q  <= 1'b0;
         halted_q  <= 1'b0;
         known_q   <= '0;
      end else begin
         order_q   <= order_c;
         prev_pc_q <= pc_c;
         pc_vld_q  <= pc_vld_c;
         halted_q  <= halted_c;
         known_q   <= known_c;
         if (errcode == '0)
            errcode <= err_c;
      end
   end

   // Shadow values have no reset. The known bits qualify them.
   always_ff @(posedge clock) begin
      if (reset)
         regs_q <= regs_c;
   end

   // Fields the monitor deliberately does not check
   logic unused_sigs;
   assign unused_sigs = ^{rvfi.rvfi_mode, rvfi.rvfi_mem_extamo, rvfi.rvfi_mem_addr,
                          rvfi.rvfi_mem_rdata, rvfi.rvfi_mem_wdata, c_insn[15:2]};
endmodule

// File: tb/tb_riscv_formal_monitor_rv32imc.sv
// Purpose: randomized and directed stimulus for the RVFI monitor, checked against a retirement-list model.
// Latency: inputs are driven 1ns after a rising edge; errcode is checked 1ns after the next rising edge.
// Backpressure: none.
module tb_riscv_formal_monitor_rv32imc;
   localparam int NRET = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] errcode;

   always #5 clk = ~clk;

   riscv_formal_monitor_rv32imc_if #(.NRET(NRET), .XLEN(32), .ILEN(32)) rvfi_bus ();

   riscv_formal_monitor_rv32imc #(.NRET(NRET), .XLEN(32), .ILEN(32)) dut (
      .clock   (clk),
      .reset   (rst_n),
      .rvfi    (rvfi_bus),
      .errcode (errcode)
   );

   typedef struct {
      bit              vld;
      longint unsigned order;
      bit [31:0]       insn;
      bit              trap, halt, intr;
      bit [4:0]        rs1, rs2, rd;
      bit [31:0]       rs1d, rs2d, rdd, pcr, pcw;
      bit [3:0]        rm, wm;
   } ret_t;

   ret_t cyc [NRET];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: the retirement stream as seen so far
   longint unsigned m_exp;
   bit [31:0]       m_pc;
   bit              m_pcv, m_halted;
   bit [31:0]       m_reg [32];
   bit [31:0]       m_known;
   int              m_err;

   bit [3:0] legal_nz [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   bit [3:0] bad_mask [8] = '{4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: errcode=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit shape_ok(input bit [3:0] m);
      bit ok = (m == 4'b0000);
      for (int k = 0; k < 7; k++) if (legal_nz[k] == m) ok = 1'b1;
      return ok;
   endfunction

   function automatic void model_reset();
      m_exp = 0; m_pc = 0; m_pcv = 0; m_halted = 0; m_known = 0; m_err = 0;
   endfunction

   // Apply one cycle's retirements in channel order. Collect every violated rule;
   // the lowest code of the first offending retirement becomes the latched error.
   function automatic void model_cycle();
      int first = 0;
      for (int i = 0; i < NRET; i++) begin
         if (cyc[i].vld) begin
            bit [110:101] hit = '0;
            int code = 0;
            hit[101] = (cyc[i].order != m_exp);
            hit[102] = m_pcv && (cyc[i].pcr != m_pc);
            hit[103] = (cyc[i].rs1 == 0) ? (cyc[i].rs1d != 0) : (m_known[cyc[i].rs1] && cyc[i].rs1d != m_reg[cyc[i].rs1]);
            hit[104] = (cyc[i].rs2 == 0) ? (cyc[i].rs2d != 0) : (m_known[cyc[i].rs2] && cyc[i].rs2d != m_reg[cyc[i].rs2]);
            hit[105] = (cyc[i].rd == 0) && (cyc[i].rdd != 0);
            hit[106] = m_halted;
            hit[107] = cyc[i].trap || cyc[i].intr;
            hit[108] = (cyc[i].insn[1:0] != 2'b11) && (cyc[i].insn[31:16] != 0);
            hit[109] = (cyc[i].rm != 0) && (cyc[i].wm != 0);
            hit[110] = !shape_ok(cyc[i].rm) || !shape_ok(cyc[i].wm);
            for (int c = 101; c <= 110; c++) if (hit[c] && code == 0) code = c;
            if (first == 0) first = code;
            m_exp++;
            m_pc = cyc[i].pcw;
            m_pcv = 1'b1;
            if (cyc[i].halt) m_halted = 1'b1;
            if (cyc[i].rd != 0) begin
               m_reg[cyc[i].rd] = cyc[i].rdd;
               m_known[cyc[i].rd] = 1'b1;
            end
         end
      end
      if (m_err == 0) m_err = first;
   endfunction

   function automatic ret_t mk(input longint unsigned ord, input bit [31:0] pc);
      ret_t r = '{default: 0};
      r.vld = 1'b1; r.order = ord; r.insn = 32'h0000_0013; r.pcr = pc; r.pcw = pc + 4;
      return r;
   endfunction

   function automatic ret_t junk();
      ret_t r;
      r.vld = 1'b0; r.order = {$urandom, $urandom}; r.insn = $urandom;
      r.trap = 1'($urandom); r.halt = 1'($urandom); r.intr = 1'($urandom);
      r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
      r.rs1d = $urandom; r.rs2d = $urandom; r.rdd = $urandom; r.pcr = $urandom; r.pcw = $urandom;
      r.rm = 4'($urandom); r.wm = 4'($urandom);
      return r;
   endfunction

   task automatic clear_cyc();
      for (int i = 0; i < NRET; i++) cyc[i] = '{default: 0};
   endtask

   // Build a mostly legal cycle from the model's current view. At most one fault is
   // injected per valid channel, with probability 1/rate (rate 0 = clean).
   task automatic gen_cycle(input int rate);
      longint unsigned g_exp = m_exp;
      bit [31:0] g_pc = m_pc;
      bit g_pcv = m_pcv;
      bit [31:0] g_reg [32];
      bit [31:0] g_known = m_known;
      g_reg = m_reg;
      for (int i = 0; i < NRET; i++) begin
         ret_t r = junk();
         int kind = -1;
         bit comp;
         if ($urandom_range(3) != 0) begin
            if (rate != 0 && $urandom_range(rate - 1) == 0) kind = $urandom_range(9);
            r.vld = 1'b1;
            r.order = g_exp + ((kind == 0) ? longint'($urandom_range(3, 1)) : 0);
            r.pcr = g_pcv ? g_pc : ($urandom & ~32'h1);
            if (kind == 1) r.pcr = r.pcr ^ 32'h10;
            comp = ($urandom_range(2) == 0) || (kind == 7);
            if (comp) begin
               r.insn = {16'h0, 16'($urandom)};
               r.insn[1:0] = 2'($urandom_range(2));
               if (kind == 7) r.insn[31:16] = 16'($urandom_range(65535, 1));
            end else begin
               r.insn = $urandom | 32'h3;
            end
            r.pcw = r.pcr + (comp ? 32'd2 : 32'd4);
            r.rs1d = (r.rs1 == 0) ? 0 : (g_known[r.rs1] ? g_reg[r.rs1] : $urandom);
            r.rs2d = (r.rs2 == 0) ? 0 : (g_known[r.rs2] ? g_reg[r.rs2] : $urandom);
            if (kind == 2) r.rs1d = r.rs1d ^ 32'h1;
            if (kind == 3) r.rs2d = r.rs2d ^ 32'h8000_0000;
            if (kind == 4) r.rd = 0;
            r.rdd = (r.rd == 0) ? ((kind == 4) ? $urandom_range(32'hffff, 1) : 0) : $urandom;
            r.halt = (kind == 5);
            r.trap = (kind == 6) && $urandom_range(1) == 0;
            r.intr = (kind == 6) && !r.trap;
            r.rm = 0; r.wm = 0;
            case ($urandom_range(2))
               1: r.rm = legal_nz[$urandom_range(6)];
               2: r.wm = legal_nz[$urandom_range(6)];
               default: ;
            endcase
            if (kind == 8) begin r.rm = legal_nz[$urandom_range(6)]; r.wm = legal_nz[$urandom_range(6)]; end
            if (kind == 9) r.wm = bad_mask[$urandom_range(7)];
            g_exp++;
            g_pc = r.pcw;
            g_pcv = 1'b1;
            if (r.rd != 0) begin g_reg[r.rd] = r.rdd; g_known[r.rd] = 1'b1; end
         end
         cyc[i] = r;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NRET; i++) begin
         rvfi_bus.rvfi_valid[i]               = cyc[i].vld;
         rvfi_bus.rvfi_order[i*64 +: 64]      = cyc[i].order;
         rvfi_bus.rvfi_insn[i*32 +: 32]       = cyc[i].insn;
         rvfi_bus.rvfi_trap[i]                = cyc[i].trap;
         rvfi_bus.rvfi_halt[i]                = cyc[i].halt;
         rvfi_bus.rvfi_intr[i]                = cyc[i].intr;
         rvfi_bus.rvfi_mode[i*2 +: 2]         = 2'($urandom);
         rvfi_bus.rvfi_rs1_addr[i*5 +: 5]     = cyc[i].rs1;
         rvfi_bus.rvfi_rs2_addr[i*5 +: 5]     = cyc[i].rs2;
         rvfi_bus.rvfi_rd_addr[i*5 +: 5]      = cyc[i].rd;
         rvfi_bus.rvfi_rs1_rdata[i*32 +: 32]  = cyc[i].rs1d;
         rvfi_bus.rvfi_rs2_rdata[i*32 +: 32]  = cyc[i].rs2d;
         rvfi_bus.rvfi_rd_wdata[i*32 +: 32]   = cyc[i].rdd;
         rvfi_bus.rvfi_pc_rdata[i*32 +: 32]   = cyc[i].pcr;
         rvfi_bus.rvfi_pc_wdata[i*32 +: 32]   = cyc[i].pcw;
         rvfi_bus.rvfi_mem_addr[i*32 +: 32]   = $urandom & ~32'h3;
         rvfi_bus.rvfi_mem_rdata[i*32 +: 32]  = $urandom;
         rvfi_bus.rvfi_mem_wdata[i*32 +: 32]  = $urandom;
         rvfi_bus.rvfi_mem_rmask[i*4 +: 4]    = cyc[i].rm;
         rvfi_bus.rvfi_mem_wmask[i*4 +: 4]    = cyc[i].wm;
         rvfi_bus.rvfi_mem_extamo[i]          = 1'($urandom);
      end
   endtask

   task automatic step();
      drive();
      @(posedge clk);
      #1;
      model_cycle();
      clear_cyc();
   endtask

   // Reset is held across two edges while garbage retirements are presented.
   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      gen_cycle(5);
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk("reset", errcode, 32'd0);
      rst_n = 1'b1;
      clear_cyc();
   endtask

   initial begin
      clear_cyc();
      drive();

      // Clean two-channel chain
      do_reset();
      cyc[0] = mk(0, 32'h6000_0000);
      cyc[1] = mk(1, 32'h6000_0004);
      step();
      chk("clean", errcode, 32'd0);
      step();
      chk("clean_idle", errcode, 32'd0);

      // Order skip, then sticky
      do_reset();
      cyc[0] = mk(0, 32'h100);
      step();
      chk("order_pre", errcode, 32'd0);
      cyc[0] = mk(2, 32'h104);
      step();
      chk("order_skip", errcode, 32'd101);
      cyc[0] = mk(3, 32'h108); cyc[0].trap = 1'b1;
      step();
      chk("order_sticky", errcode, 32'd101);

      // Same-cycle forwarding of x5 into a higher channel's rs1
      do_reset();
      cyc[0] = mk(0, 32'h200); cyc[0].rd = 5; cyc[0].rdd = 32'h1234;
      cyc[3] = mk(1, 32'h204); cyc[3].rs1 = 5; cyc[3].rs1d = 32'h1235;
      step();
      chk("fwd_rs1", errcode, 32'd103);

      // Matching forwarded value on rs2 is clean
      do_reset();
      cyc[0] = mk(0, 32'h200); cyc[0].rd = 7; cyc[0].rdd = 32'hcafe;
      cyc[5] = mk(1, 32'h204); cyc[5].rs2 = 7; cyc[5].rs2d = 32'hcafe;
      step();
      chk("fwd_ok", errcode, 32'd0);

      // Trap on ch1 beats the x0 write on ch2
      do_reset();
      cyc[1] = mk(0, 32'h300); cyc[1].trap = 1'b1;
      cyc[2] = mk(1, 32'h304); cyc[2].rd = 0; cyc[2].rdd = 32'h1;
      step();
      chk("prio_chan", errcode, 32'd107);

      // Lowest code wins within one channel (order 101 and mask 109)
      do_reset();
      cyc[4] = mk(9, 32'h400); cyc[4].rm = 4'b0001; cyc[4].wm = 4'b0001;
      step();
      chk("prio_code", errcode, 32'd101);

      // Halt followed by another retirement
      do_reset();
      cyc[0] = mk(0, 32'h500); cyc[0].halt = 1'b1;
      step();
      chk("halt_pre", errcode, 32'd0);
      cyc[0] = mk(1, 32'h504);
      step();
      chk("halt_next", errcode, 32'd106);

      // Compressed with a nonzero upper half, and an illegal mask shape
      do_reset();
      cyc[0] = mk(0, 32'h600); cyc[0].insn = 32'h0001_0001;
      step();
      chk("comp_bad", errcode, 32'd108);
      do_reset();
      cyc[2] = mk(0, 32'h600); cyc[2].rm = 4'b0110;
      step();
      chk("mask_shape", errcode, 32'd110);

      // PC break, then asynchronous reset between edges clears at once
      do_reset();
      cyc[0] = mk(0, 32'h700);
      step();
      cyc[0] = mk(1, 32'h800);
      step();
      chk("pc_break", errcode, 32'd102);
      rst_n = 1'b0;
      #2;
      chk("async_rst", errcode, 32'd0);
      rst_n = 1'b1;
      model_reset();
      cyc[0] = mk(0, 32'h1234_0000);
      step();
      chk("post_rst", errcode, 32'd0);

      // Randomized episodes against the model
      for (int ep = 0; ep < 40; ep++) begin
         int rate;
         do_reset();
         rate = (ep % 4 == 0) ? 0 : ((ep % 4 == 1) ? 200 : 60);
         for (int c = 0; c < 30; c++) begin
            gen_cycle(rate);
            step();
            chk("rand", errcode, 32'(m_err));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/riscv_formal_monitor_rv32imc.md
RISCV_FORMAL_MONITOR_RV32IMC -- requirements
Module: riscv_formal_monitor_rv32imc

Interface
REQ-001 Parameters SHALL be: NRET, 8, retirement channels per cycle; XLEN, 32, data width; ILEN, 32, instruction width.
REQ-002 Channel i of every packed port SHALL occupy slice [i*W +: W], where W is the per-channel width.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rvfi_valid  in  8  per-channel retirement valid.
REQ-006 rvfi_order  in  512  64-bit retirement sequence number per channel.
REQ-007 rvfi_insn  in  256  instruction word per channel; a compressed instruction occupies [15:0].
REQ-008 rvfi_trap / rvfi_halt / rvfi_intr  in  8 each  per-channel flags.
REQ-009 rvfi_mode  in  16  2-bit privilege per channel; ignored.
REQ-010 rvfi_rs1_addr / rvfi_rs2_addr / rvfi_rd_addr  in  40 each  5-bit register index per channel.
REQ-011 rvfi_rs1_rdata / rvfi_rs2_rdata / rvfi_rd_wdata  in  256 each  32-bit data per channel.
REQ-012 rvfi_pc_rdata / rvfi_pc_wdata  in  256 each  current and next PC per channel.
REQ-013 rvfi_mem_addr / rvfi_mem_rdata / rvfi_mem_wdata  in  256 each  word-aligned address and data per channel.
REQ-014 rvfi_mem_rmask / rvfi_mem_wmask  in  32 each  4-bit byte masks per channel.
REQ-015 rvfi_mem_extamo  in  8  ignored.
REQ-016 errcode  out  16  registered error code; 0 means no error.

Function
REQ-017 Valid channels in a cycle SHALL be processed in ascending channel index as consecutive retirements; invalid channels are skipped, and gaps are legal.
REQ-018 The monitor SHALL keep an expected-order counter (64-bit, reset 0), incremented once per valid retirement.
  - Mismatch between rvfi_order and the expected value -> code 101.
REQ-019 PC continuity: pc_rdata of each retirement SHALL equal pc_wdata of the previous retirement, chained across channels within a cycle and across cycles.
  - The first retirement after reset is unchecked.
  - Mismatch -> code 102.
REQ-020 Shadow register file: x1..x31 SHALL be held as 32-bit values, each with a known bit (all cleared at reset).
  - A retirement with rd_addr!=0 writes the value and sets the known bit.
  - Writes from lower channels in the same cycle SHALL be visible to higher channels.
REQ-021 Source operand checks, for rs1 and rs2:
  - addr!=0 and known, rdata differing from shadow -> code 103 (rs1) / 104 (rs2).
  - addr==0 with rdata!=0 -> the same code.
  - addr!=0 and not known -> unchecked.
REQ-022 rd_addr==0 with rd_wdata!=0 -> code 105.
REQ-023 Any valid retirement on a later cycle, or a higher channel, after a retirement with halt=1 -> code 106.
REQ-024 Any valid retirement with trap=1 or intr=1 -> code 107.
REQ-025 Compressed-encoding check: insn[1:0]!=2'b11 with insn[31:16]!=0 -> code 108.
REQ-026 Memory mask checks:
  - rmask!=0 and wmask!=0 on the same retirement -> code 109.
  - A nonzero mask not in {0001, 0010, 0100, 1000, 0011, 1100, 1111} -> code 110.
REQ-027 Only retirements with valid=1 SHALL be checked; inputs of invalid channels have no effect.
REQ-028 errcode SHALL be registered and latch the first error one clock after the offending retirement is sampled.
  - It is sticky until reset.
  - Later errors SHALL NOT overwrite it.
REQ-029 Priority for multiple errors in one cycle:
  - The lowest channel wins.
  - Within a channel, the lowest code number wins.
REQ-030 State (order counter, previous pc_wdata, shadow file, halted flag) SHALL still update on retirements that raise an error.

Reset
REQ-031 Asserting reset low SHALL asynchronously clear errcode, the order counter, the halted flag, the PC-valid flag and all shadow known bits, including mid-cycle.
REQ-032 No retirement SHALL be sampled while reset is low; checking resumes at the first rising edge after deassertion.

Verification
REQ-033 Order and PC, clean case: ch0 order=0, pc 0x60000000->0x60000004; ch1 order=1, pc 0x60000004->0x60000008 -> errcode stays 0.
REQ-034 Order skip: cycle 1 ch0 order=0; cycle 2 ch0 order=2 -> errcode=101 one cycle later and held thereafter.
REQ-035 Same-cycle register forwarding: ch0 rd=x5 wdata=0x1234; ch3 rs1=x5 rdata=0x1235 -> errcode=104? No: errcode=103.
REQ-036 x0 writes and priority: ch2 rd=x0 wdata=1 and ch1 trap=1 in the same cycle -> errcode=107, since the lower channel wins.
REQ-037 Halt: ch0 halt=1, then next cycle ch0 valid=1 -> errcode=106.
REQ-038 Reset mid-run: errcode=102 latched; pulse reset low asynchronously -> errcode=0 immediately, and a subsequent order=0 retirement passes.
